rgb2ycbcr_param: RTL

Parametrised, stallable RGB-to-YCbCr colour-space converter for the video pipeline, placed between the RGB pixel source (camera or framebuffer) and the YCbCr consumers (skin-detect, binarisation, luma-only paths). It accepts RGB at any per-channel width from 1 to 8 bits and expands each channel to 8 bits. Three coefficient sets (BT.601 full, BT.709 full, BT.601 limited) are selectable at run time, and a new selection takes effect only at a frame boundary. Outputs are rounded and saturated, and the sync signals are delayed to stay aligned with the data through a clock-enabled 3-stage pipeline.

---
 rtl/rgb2ycbcr_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rgb2ycbcr_param.sv
// RGB (R_W/G_W/B_W bits) to 8-bit YCbCr with run-time coefficient set, latched at vsync rise.
// Latency 3 ce cycles; ce=0 freezes every register so the whole pipe stalls in place.
module rgb2ycbcr_param #(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [1:0]     mode_sel,
    input  logic           pre_frame_vsync,
    input  logic           pre_frame_hsync,
    input  logic           pre_frame_de,
    input  logic [R_W-1:0] img_red,
    input  logic [G_W-1:0] img_green,
    input  logic [B_W-1:0] img_blue,
    output logic           post_frame_vsync,
    output logic           post_frame_hsync,
    output logic           post_frame_de,
    output logic [7:0]     img_y,
    output logic [7:0]     img_cb,
    output logic [7:0]     img_cr,
    output logic [1:0]     mode_active
);

    // Row-major: index = row*3 + channel, rows Y/Cb/Cr, channels R/G/B.
    function automatic logic signed [8:0] coef(input logic [1:0] m, input int idx);
        logic signed [8:0] c;
        c = 9'sd0;
        case (m)
            2'd1: case (idx)
                0: c = 9'sd54;   1: c = 9'sd183;  2: c = 9'sd19;
                3: c = -9'sd29;  4: c = -9'sd99;  5: c = 9'sd128;
                6: c = 9'sd128;  7: c = -9'sd116; default: c = -9'sd12;
            endcase
            2'd2: case (idx)
                0: c = 9'sd66;   1: c = 9'sd129;  2: c = 9'sd25;
                3: c = -9'sd38;  4: c = -9'sd74;  5: c = 9'sd112;
                6: c = 9'sd112;  7: c = -9'sd94;  default: c = -9'sd18;
            endcase
            default: case (idx)
                0: c = 9'sd77;   1: c = 9'sd150;  2: c = 9'sd29;
                3: c = -9'sd43;  4: c = -9'sd85;  5: c = 9'sd128;
                6: c = 9'sd128;  7: c = -9'sd107; default: c = -9'sd21;
            endcase
        endcase
        return c;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [19:0] v,
                                          input logic [7:0] lo, input logic [7:0] hi);
        if (v < $signed({12'd0, lo}))
            return lo;
        else if (v > $signed({12'd0, hi}))
            return hi;
        else
            return v[7:0];
    endfunction

    logic [7:0]         red8, green8, blue8;
    logic [7:0]         px [3];
    logic               vs_prev_q;
    logic [1:0]         mode_q, mode_new, mode_use;
    logic               vs_rise;
    logic signed [17:0] prod_d [9];
    logic signed [17:0] prod_q [9];
    logic signed [19:0] sum_d [3];
    logic signed [19:0] sum_q [3];
    logic [7:0]         res_d [3];
    logic [7:0]         res_q [3];
    logic [1:0]         mode1_q, mode2_q;
    logic [2:0]         sync1_q, sync2_q, sync3_q;

    // Cyclic MSB replication: bit 7-k takes source bit W-1-(k mod W).
    for (genvar k = 0; k < 8; k++) begin : g_expand
        assign red8[7-k]   = img_red[R_W-1-(k%R_W)];
        assign green8[7-k] = img_green[G_W-1-(k%G_W)];
        assign blue8[7-k]  = img_blue[B_W-1-(k%B_W)];
    end
    assign px[0] = red8;
    assign px[1] = green8;
    assign px[2] = blue8;

    assign mode_new = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
    assign vs_rise  = pre_frame_vsync & ~vs_prev_q;
    assign mode_use = vs_rise ? mode_new : mode_q;

    for (genvar j = 0; j < 9; j++) begin : g_prod
        logic signed [8:0] c;
        assign c         = coef(mode_use, j);
        assign prod_d[j] = $signed({10'd0, px[j%3]}) * $signed({{9{c[8]}}, c});
    end

    for (genvar k = 0; k < 3; k++) begin : g_row
        logic signed [19:0] off;
        logic [7:0]         lo, hi;
        if (k == 0) begin : g_y_off
            assign off = (mode1_q == 2'd2) ? 20'sd4096 : 20'sd0;
        end else begin : g_c_off
            assign off = 20'sd32768;
        end
        assign sum_d[k] = $signed({{2{prod_q[3*k][17]}},   prod_q[3*k]})
                        + $signed({{2{prod_q[3*k+1][17]}}, prod_q[3*k+1]})
                        + $signed({{2{prod_q[3*k+2][17]}}, prod_q[3*k+2]})
                        + off + 20'sd128;
        assign lo = (mode2_q == 2'd2) ? 8'd16 : 8'd0;
        assign hi = (mode2_q == 2'd2) ? ((k == 0) ? 8'd235 : 8'd240) : 8'd255;
        assign res_d[k] = sync2_q[0] ? clamp8(sum_q[k] >>> 8, lo, hi) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            mode_q    <= 2'd0;
            prod_q    <= '{default: '0};
            sum_q     <= '{default: '0};
            res_q     <= '{default: '0};
            mode1_q   <= 2'd0;
            mode2_q   <= 2'd0;
            sync1_q   <= 3'd0;
            sync2_q   <= 3'd0;
            sync3_q   <= 3'd0;
        end else if (ce) begin
            vs_prev_q <= pre_frame_vsync;
            if (vs_rise)
                mode_q <= mode_new;
            prod_q  <= prod_d;
            mode1_q <= mode_use;
            sync1_q <= {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
            sum_q   <= sum_d;
            mode2_q <= mode1_q;
            sync2_q <= sync1_q;
            res_q   <= res_d;
            sync3_q <= sync2_q;
        end
    end

    assign post_frame_vsync = sync3_q[2];
    assign post_frame_hsync = sync3_q[1];
    assign post_frame_de    = sync3_q[0];
    assign img_y            = res_q[0];
    assign img_cb           = res_q[1];
    assign img_cr           = res_q[2];
    assign mode_active      = mode_q;

endmodule
